usrt_tx_serializer: RTL and testbench
=====================================

Name: usrt_tx_serializer

Overview:
- Parametrised USRT transmitter. Accepts a parallel word over a valid/ready handshake and builds the frame: start, data, optional parity, stop.
- Frame is shifted out serially, one bit per i_Pclk cycle.
- Generalises the fixed 8-bit framer to configurable data width, stop-bit count and a no-parity mode.
- Supports back-to-back gapless frames. Sits between the host-side TX buffer and the USRT line driver.

Parameters:
- DATA_WIDTH, 8, data bits per frame (5..16).
- STOP_BITS, 1, stop bits per frame (1..2).

Ports:
- i_Pclk  input  1  bit clock; one line bit per rising edge. Single clock domain.
- i_Rst_n  input  1  asynchronous, active-low reset.
- i_Parity  input  2  parity mode, sampled at acceptance: 2'b01 odd, 2'b10 even, 2'b00/2'b11 none.
- i_Data  input  DATA_WIDTH  word to send, sampled at acceptance.
- i_Valid  input  1  word available.
- o_Ready  output  1  block can accept a word this cycle.
- o_Tx  output  1  serial line, idles high.
- o_Busy  output  1  frame in progress.
- o_Done  output  1  one-cycle pulse on the last stop-bit cycle of each frame.

Behaviour:
- Reset (async assert, sync release): state IDLE; o_Tx=1, o_Ready=1, o_Busy=0, o_Done=0; shift register, bit counter and latched parity mode cleared.
- All outputs are registered except o_Ready, which is decoded from state.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept: i_Valid && o_Ready at an edge latches i_Data, i_Parity and the computed parity bit.
- Transitions and line values:
  - IDLE: o_Tx=1. Accept -> START.
  - START: o_Tx=0 for 1 cycle -> DATA.
  - DATA: o_Tx=data bit, LSB first, for DATA_WIDTH cycles. Counter runs 0..DATA_WIDTH-1. Afterwards -> PARITY if mode is odd/even, else -> STOP.
  - PARITY: o_Tx=parity bit for 1 cycle -> STOP.
  - STOP: o_Tx=1 for STOP_BITS cycles. On the last stop cycle: accept -> START, otherwise -> IDLE.
- Latency: start bit appears on o_Tx in the cycle after acceptance.
- Frame length: 1 + DATA_WIDTH + P + STOP_BITS cycles, where P=1 with parity and 0 without. Default with parity is 11 cycles.
- o_Ready is 1 in IDLE and in the last STOP cycle, 0 elsewhere. Back-to-back: a word accepted in the last stop cycle starts its start bit next cycle, with no idle gap.
- Parity bit:
  - even = XOR of the data bits;
  - odd = inverted XOR of the data bits;
  - computed over exactly DATA_WIDTH bits.
- o_Busy=1 from START through the last STOP cycle. o_Busy stays 1 across back-to-back frames.
- o_Done pulses in the last STOP cycle regardless of whether a new word is accepted.
- Changing i_Data or i_Parity mid-frame has no effect; both are latched at acceptance.
- i_Valid may drop without acceptance; no word is queued.
- Reset mid-frame: o_Tx returns to 1 immediately (asynchronous). The partial frame is abandoned and is not resumed.

Optional Feature:
- Macro USRT_TX_BITEN_EN.
- Defined:
  - Adds input i_BitEn (1 bit).
  - State, counter and shift register advance only on edges with i_BitEn=1; o_Tx holds between enables.
  - Acceptance still requires only i_Valid && o_Ready, so a word may be accepted without i_BitEn. START then holds until the next i_BitEn.
  - o_Ready and o_Done are qualified with i_BitEn in the last STOP cycle.
- Undefined: no i_BitEn port; the block advances every cycle, as described above.

Decomposition:
- Package usrt_pkg holds:
  - parity encodings PAR_NONE=2'b00, PAR_ODD=2'b01, PAR_EVEN=2'b10;
  - the state encoding;
  - DATA_WIDTH/STOP_BITS range-check constants.
- One sub-module, usrt_parity_gen: parametrised DATA_WIDTH, combinational; takes data and mode, returns the parity bit. Shared with the future receiver for checking.

Test Plan:
- Reset then idle: i_Rst_n=0 -> o_Tx=1, o_Ready=1, o_Busy=0, o_Done=0. Hold idle 20 cycles -> o_Tx stays 1.
- Odd parity: i_Data=8'h35, i_Parity=01 -> o_Tx sequence 0,1,0,1,0,1,1,0,0,1,1 (parity=1). o_Done pulses in cycle 11.
- Even parity: i_Data=8'h35, then 8'h34, i_Parity=10 -> parity bits 0 and 1 respectively. Repeat 8'h34 with odd -> 0.
- No parity with DATA_WIDTH=7, STOP_BITS=2: i_Data=7'h55, i_Parity=00 -> 10-cycle frame 0,1,0,1,0,1,0,1,1,1.
- Back-to-back: i_Valid held high with 8'hA5 then 8'h3C -> second start bit immediately follows first stop bit. o_Busy never drops; two o_Done pulses 11 cycles apart.
- Mid-frame reset: assert i_Rst_n=0 during DATA bit 3 -> o_Tx=1 asynchronously. After release, o_Ready=1 and the next frame is complete and correct.

Source files
------------

// File: rtl/usrt_pkg.sv
// Shared USRT definitions: parity encodings, FSM states, legal parameter ranges.
// Used by the transmitter and the parity generator.
package usrt_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam int DW_MIN = 5;
    localparam int DW_MAX = 16;
    localparam int SB_MIN = 1;
    localparam int SB_MAX = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    function automatic logic par_en(input logic [1:0] mode);
        return (mode == PAR_ODD) || (mode == PAR_EVEN);
    endfunction

    function automatic bit cfg_ok(input int dw, input int sb);
        return (dw >= DW_MIN) && (dw <= DW_MAX) &&
               (sb >= SB_MIN) && (sb <= SB_MAX);
    endfunction

endpackage

// File: rtl/usrt_parity_gen.sv
// Combinational parity bit over DATA_WIDTH data bits.
// Zero when the mode selects no parity.
module usrt_parity_gen
    import usrt_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_Data,
    input  logic [1:0]            i_Mode,
    output logic                  o_Parity
);

    always_comb begin
        o_Parity = 1'b0;
        case (i_Mode)
            PAR_ODD:  o_Parity = ~^i_Data;
            PAR_EVEN: o_Parity = ^i_Data;
            default:  o_Parity = 1'b0;
        endcase
    end

endmodule

// File: rtl/usrt_tx_serializer.sv
// USRT transmitter: start, DATA_WIDTH bits LSB first, optional parity, stop.
// Define USRT_TX_BITEN_EN to add the i_BitEn bit-enable input.
module usrt_tx_serializer
    import usrt_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  i_Pclk,
    input  logic                  i_Rst_n,
    input  logic [1:0]            i_Parity,
    input  logic [DATA_WIDTH-1:0] i_Data,
    input  logic                  i_Valid,
`ifdef USRT_TX_BITEN_EN
    input  logic                  i_BitEn,
`endif
    output logic                  o_Ready,
    output logic                  o_Tx,
    output logic                  o_Busy,
    output logic                  o_Done
);

    localparam int CW = $clog2(DATA_WIDTH);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [1:0]              mode_q, mode_d;
    logic                    par_q, par_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    par_calc;
    logic                    adv;
    logic                    last_stop;
    logic                    accept;

    usrt_parity_gen #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_par (
        .i_Data  (i_Data),
        .i_Mode  (i_Parity),
        .o_Parity(par_calc)
    );

`ifdef USRT_TX_BITEN_EN
    assign adv    = i_BitEn;
    assign o_Done = done_q && i_BitEn;
`else
    assign adv    = 1'b1;
    assign o_Done = done_q;
`endif

    assign last_stop = (state_q == S_STOP) && (cnt_q == CW'(STOP_BITS - 1));
    assign o_Ready   = (state_q == S_IDLE) || (last_stop && adv);
    assign accept    = i_Valid && o_Ready;
    assign o_Tx      = tx_q;
    assign o_Busy    = busy_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        par_d   = par_q;
        if (accept) begin
            state_d = S_START;
            shift_d = i_Data;
            mode_d  = i_Parity;
            par_d   = par_calc;
            cnt_d   = '0;
        end else if (adv) begin
            unique case (state_q)
                S_IDLE: ;
                S_START: begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
                S_DATA: begin
                    if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                        state_d = par_en(mode_q) ? S_PARITY : S_STOP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        shift_d = shift_q >> 1;
                    end
                end
                S_PARITY: begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                end
                S_STOP: begin
                    if (last_stop) state_d = S_IDLE;
                    else           cnt_d   = cnt_q + CW'(1);
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Line value is registered from the next state so it changes with the state.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_STOP) && (cnt_d == CW'(STOP_BITS - 1));
    end

    always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            mode_q  <= PAR_NONE;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_usrt_tx_serializer.sv
// Directed scoreboard bench for usrt_tx_serializer (8N1-style default and 7-bit/2-stop instance).
// Expected line bits are queued when a word is driven and compared bit by bit.
module tb_usrt_tx_serializer;

    typedef struct {
        logic tx;
        logic done;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       v8, v7;
    logic [7:0] d8;
    logic [6:0] d7;
    logic [1:0] p8, p7;
    logic       r8, tx8, b8, dn8;
    logic       r7, tx7, b7, dn7;

    int checks = 0;
    int errors = 0;

    exp_t q8[$];
    exp_t q7[$];

    usrt_tx_serializer #(
        .DATA_WIDTH(8),
        .STOP_BITS (1)
    ) u_dut8 (
        .i_Pclk  (clk),
        .i_Rst_n (rst_n),
        .i_Parity(p8),
        .i_Data  (d8),
        .i_Valid (v8),
        .o_Ready (r8),
        .o_Tx    (tx8),
        .o_Busy  (b8),
        .o_Done  (dn8)
    );

    usrt_tx_serializer #(
        .DATA_WIDTH(7),
        .STOP_BITS (2)
    ) u_dut7 (
        .i_Pclk  (clk),
        .i_Rst_n (rst_n),
        .i_Parity(p7),
        .i_Data  (d7),
        .i_Valid (v7),
        .o_Ready (r7),
        .o_Tx    (tx7),
        .o_Busy  (b7),
        .o_Done  (dn7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input bit sel7, input logic [15:0] d,
                              input int dw, input logic [1:0] p,
                              input int sb);
        exp_t e;
        logic x;
        x      = 1'b0;
        e.tx   = 1'b0;
        e.done = 1'b0;
        if (sel7) q7.push_back(e); else q8.push_back(e);
        for (int i = 0; i < dw; i++) begin
            e.tx = d[i];
            x    = x ^ d[i];
            if (sel7) q7.push_back(e); else q8.push_back(e);
        end
        if (p == 2'b01 || p == 2'b10) begin
            e.tx = (p == 2'b01) ? ~x : x;
            if (sel7) q7.push_back(e); else q8.push_back(e);
        end
        for (int i = 0; i < sb; i++) begin
            e.tx   = 1'b1;
            e.done = (i == sb - 1);
            if (sel7) q7.push_back(e); else q8.push_back(e);
        end
    endtask

    task automatic drain8(input int n_chg, input logic [7:0] nd,
                          input logic [1:0] np, input int n_drop);
        exp_t e;
        int   n;
        n = 0;
        while (q8.size() > 0) begin
            @(negedge clk);
            n++;
            e = q8.pop_front();
            chk("tx8", tx8, e.tx);
            chk("done8", dn8, e.done);
            chk("ready8", r8, e.done);
            chk("busy8", b8, 1'b1);
            if (n == n_chg) begin
                d8 = nd;
                p8 = np;
            end
            if (n == n_drop) v8 = 1'b0;
        end
    endtask

    task automatic drain7();
        exp_t e;
        int   n;
        n = 0;
        while (q7.size() > 0) begin
            @(negedge clk);
            n++;
            e = q7.pop_front();
            chk("tx7", tx7, e.tx);
            chk("done7", dn7, e.done);
            chk("ready7", r7, e.done);
            chk("busy7", b7, 1'b1);
            if (n == 1) begin
                v7 = 1'b0;
                d7 = 7'h2A;
            end
        end
    endtask

    task automatic idle8(input string tag);
        @(negedge clk);
        chk({tag, "_tx"}, tx8, 1'b1);
        chk({tag, "_busy"}, b8, 1'b0);
        chk({tag, "_done"}, dn8, 1'b0);
        chk({tag, "_ready"}, r8, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        v8 = 1'b0; d8 = '0; p8 = 2'b00;
        v7 = 1'b0; d7 = '0; p7 = 2'b00;
        repeat (2) @(negedge clk);
        chk("rst_tx", tx8, 1'b1);
        chk("rst_ready", r8, 1'b1);
        chk("rst_busy", b8, 1'b0);
        chk("rst_done", dn8, 1'b0);
        chk("rst_tx7", tx7, 1'b1);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_tx", tx8, 1'b1);
        end

        // Odd parity 0x35, inputs scrambled mid-frame
        d8 = 8'h35; p8 = 2'b01; v8 = 1'b1;
        push_frame(1'b0, 16'h35, 8, 2'b01, 1);
        drain8(1, 8'hFF, 2'b10, 1);
        idle8("after_odd35");

        d8 = 8'h35; p8 = 2'b10; v8 = 1'b1;
        push_frame(1'b0, 16'h35, 8, 2'b10, 1);
        drain8(1, 8'h00, 2'b01, 1);
        idle8("after_even35");

        d8 = 8'h34; p8 = 2'b10; v8 = 1'b1;
        push_frame(1'b0, 16'h34, 8, 2'b10, 1);
        drain8(1, 8'h00, 2'b00, 1);
        idle8("after_even34");

        d8 = 8'h34; p8 = 2'b01; v8 = 1'b1;
        push_frame(1'b0, 16'h34, 8, 2'b01, 1);
        drain8(1, 8'h00, 2'b11, 1);
        idle8("after_odd34");

        // Back-to-back: valid stays high, second word waits in the data input
        d8 = 8'hA5; p8 = 2'b01; v8 = 1'b1;
        push_frame(1'b0, 16'hA5, 8, 2'b01, 1);
        push_frame(1'b0, 16'h3C, 8, 2'b01, 1);
        drain8(1, 8'h3C, 2'b01, 12);
        idle8("after_b2b");

        // Reset during data bit 3
        d8 = 8'h35; p8 = 2'b01; v8 = 1'b1;
        @(negedge clk);
        chk("mr_start", tx8, 1'b0);
        v8 = 1'b0;
        repeat (4) @(negedge clk);
        chk("mr_bit3", tx8, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_tx_async", tx8, 1'b1);
        chk("mr_busy", b8, 1'b0);
        chk("mr_ready", r8, 1'b1);
        chk("mr_done", dn8, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle8("mr_idle");

        d8 = 8'hC7; p8 = 2'b10; v8 = 1'b1;
        push_frame(1'b0, 16'hC7, 8, 2'b10, 1);
        drain8(1, 8'h00, 2'b00, 1);
        idle8("after_mr_frame");

        // 7 data bits, no parity, 2 stop bits
        d7 = 7'h55; p7 = 2'b00; v7 = 1'b1;
        push_frame(1'b1, 16'h55, 7, 2'b00, 2);
        drain7();
        @(negedge clk);
        chk("w7_idle_tx", tx7, 1'b1);
        chk("w7_idle_busy", b7, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
